// File: rtl/gate_sweep_pkg.sv
// ============================================================================
// gate_sweep_pkg : mode encodings, FSM states and width helper for the sweep checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package gate_sweep_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_NAND = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One extra bit so a sweep where every pattern fails (2^n) is representable.
    function automatic int err_cnt_width(input int n);
        return n + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// gate_ref_model : combinational expected-output function for one gate type
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2:0]   mode,
    input  logic [N-1:0] vector,
    output logic         expected
);

    always_comb begin
        expected = ~&vector;
        case (mode)
            MODE_AND:  expected = &vector;
            MODE_NAND: expected = ~&vector;
            MODE_OR:   expected = |vector;
            MODE_NOR:  expected = ~|vector;
            MODE_XOR:  expected = ^vector;
            MODE_XNOR: expected = ~^vector;
            default:   expected = ~&vector;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ============================================================================
// gate_sweep_checker : drives all 2^N input patterns into a gate and checks the response
// Optional truth-table trace output enabled by macro GATE_SWEEP_TRACE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [2:0]                         mode,
    output logic [N-1:0]                       dut_in,
    input  logic                               dut_out,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [gate_sweep_pkg::err_cnt_width(N)-1:0] err_cnt,
    output logic [N-1:0]                       first_err_vec
`ifdef GATE_SWEEP_TRACE_EN
    ,
    output logic [(1<<N)-1:0]                  tt_capture
`endif
);

    localparam int             C_ERR_W     = err_cnt_width(N);
    localparam logic [7:0]     C_HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N-1:0]   C_LAST_VEC  = '1;
    localparam logic [N-1:0]   C_VEC_ONE   = N'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_mode;
    logic [7:0]           r_hold;
    logic [N-1:0]         r_dut_in;
    logic [C_ERR_W-1:0]   r_err_cnt;
    logic [N-1:0]         r_first_err;
    logic                 r_pass;
    logic                 w_expected;
    logic                 w_sample;
    logic                 w_mismatch;
    logic                 w_last;
    logic [C_ERR_W-1:0]   w_err_next;

    gate_ref_model #(
        .N (N)
    ) u_ref (
        .mode     (r_mode),
        .vector   (r_dut_in),
        .expected (w_expected)
    );

    // Response is judged only on the final cycle of each pattern's hold window.
    assign w_sample   = (r_state == ST_DRIVE) && (r_hold == C_HOLD_LAST);
    assign w_last     = w_sample && (r_dut_in == C_LAST_VEC);
    assign w_mismatch = w_sample && (dut_out != w_expected);
    assign w_err_next = w_mismatch ? (r_err_cnt + C_ERR_W'(1)) : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_DRIVE;
            ST_DRIVE: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= MODE_AND;
            r_hold      <= 8'd0;
            r_dut_in    <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_hold      <= 8'd0;
                        r_dut_in    <= '0;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && (r_err_cnt == '0)) begin
                            r_first_err <= r_dut_in;
                        end
                        r_hold <= 8'd0;
                        if (w_last) begin
                            r_dut_in <= '0;
                            r_pass   <= (w_err_next == '0);
                        end else begin
                            r_dut_in <= r_dut_in + C_VEC_ONE;
                        end
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GATE_SWEEP_TRACE_EN
    logic [(1<<N)-1:0] r_tt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_tt <= '0;
        end else if (w_sample) begin
            r_tt[r_dut_in] <= dut_out;
        end
    end

    assign tt_capture = r_tt;
`endif

    assign dut_in        = r_dut_in;
    assign busy          = (r_state == ST_DRIVE);
    assign done          = (r_state == ST_DONE);
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_vec = r_first_err;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ============================================================================
// tb_gate_sweep_checker : directed and random sweeps against a truth-table reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_sweep_checker;

    localparam int N     = 4;
    localparam int HOLD  = 10;
    localparam int NPAT  = 16;
    localparam int SWEEP = NPAT * HOLD;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   mode;
    logic [N-1:0] dut_in;
    logic         dut_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_err_vec;
`ifdef GATE_SWEEP_TRACE_EN
    logic [NPAT-1:0] tt_capture;
`endif

    logic [NPAT-1:0] dut_tt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Device under check modelled as an arbitrary truth table.
    assign dut_out = dut_tt[dut_in];

    gate_sweep_checker #(
        .N    (N),
        .HOLD (HOLD)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_vec (first_err_vec)
`ifdef GATE_SWEEP_TRACE_EN
        ,
        .tt_capture    (tt_capture)
`endif
    );

    // Gate behaviour from the number of high inputs.
    function automatic logic ref_f(input logic [2:0] m, input int k);
        int ones;
        logic [3:0] kv;
        kv   = 4'(k);
        ones = $countones(kv);
        case (m)
            3'd0:    return ones == 4;
            3'd1:    return ones != 4;
            3'd2:    return ones > 0;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return ones != 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input logic [2:0] m, input logic [NPAT-1:0] tt, input bit disturb);
        int prefix [0:NPAT];
        int first_k;
        first_k   = -1;
        prefix[0] = 0;
        for (int k = 0; k < NPAT; k++) begin
            if (tt[k] != ref_f(m, k)) begin
                if (first_k < 0) first_k = k;
                prefix[k+1] = prefix[k] + 1;
            end else begin
                prefix[k+1] = prefix[k];
            end
        end
        @(negedge clk);
        mode   = m;
        dut_tt = tt;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= SWEEP; n++) begin
            chk("busy_in_sweep", busy, 1);
            chk("done_early", done, 0);
            chk("pass_cleared", pass, 0);
            chk("dut_in_pattern", dut_in, (n - 1) / HOLD);
            chk("err_running", err_cnt, prefix[(n - 1) / HOLD]);
            if (disturb && n == 40) begin
                start = 1'b1;
                mode  = 3'd3;
            end
            if (disturb && n == 41) start = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("dut_in_done", dut_in, 0);
        chk("err_final", err_cnt, prefix[NPAT]);
        chk("pass_final", pass, (prefix[NPAT] == 0) ? 1 : 0);
        if (first_k >= 0) chk("first_err_vec", first_err_vec, first_k);
`ifdef GATE_SWEEP_TRACE_EN
        chk("tt_capture", tt_capture, tt);
`endif
        repeat (4) @(negedge clk);
        chk("done_deasserted", done, 0);
        chk("busy_idle", busy, 0);
        chk("err_hold_idle", err_cnt, prefix[NPAT]);
        chk("pass_hold_idle", pass, (prefix[NPAT] == 0) ? 1 : 0);
        if (first_k >= 0) chk("first_hold_idle", first_err_vec, first_k);
    endtask

    initial begin
        logic [2:0]      rm;
        logic [NPAT-1:0] rt;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = 3'd0;
        dut_tt = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_first", first_err_vec, 0);
        chk("rst_dut_in", dut_in, 0);
        rst = 1'b0;

        run_sweep(3'd1, 16'h7FFF, 1'b0);
        run_sweep(3'd1, 16'hFFFF, 1'b0);
        run_sweep(3'd0, 16'h7FFF, 1'b0);

        @(negedge clk);
        mode   = 3'd0;
        dut_tt = 16'h7FFF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst_err", err_cnt, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_dut_in", dut_in, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_done", done, 0);
        chk("midrst_first", first_err_vec, 0);
`ifdef GATE_SWEEP_TRACE_EN
        chk("midrst_tt", tt_capture, 0);
`endif
        rst = 1'b0;

        run_sweep(3'd1, 16'h7FFF, 1'b0);
        run_sweep(3'd1, 16'h7FFF, 1'b1);
        run_sweep(3'd4, 16'h6996, 1'b0);
        run_sweep(3'd7, 16'h7FFF, 1'b0);
        run_sweep(3'd5, 16'h9669, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rm = 3'($urandom_range(0, 7));
            rt = 16'($urandom);
            run_sweep(rm, rt, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, on ports clk and rst.
REQ-002 Parameter N, default 4, number of DUT gate inputs; legal range 1..8.
REQ-003 Parameter HOLD, default 10, clk cycles each input pattern is held; legal range 2..255.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port start  in  1  request a sweep; sampled only in IDLE.
REQ-007 Port mode  in  3  expected function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 behave as NAND.
REQ-008 Port dut_in  out  N  stimulus to the DUT; bit N-1 is input a, bit 0 is the fastest-toggling input.
REQ-009 Port dut_out  in  1  DUT response.
REQ-010 Port busy  out  1  high while a sweep is in progress.
REQ-011 Port done  out  1  one-cycle pulse when a sweep completes.
REQ-012 Port pass  out  1  high when the last completed sweep had zero mismatches.
REQ-013 Port err_cnt  out  N+1  mismatch count of the current or last sweep.
REQ-014 Port first_err_vec  out  N  pattern of the first mismatch; valid only when err_cnt is nonzero.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE and DONE.
REQ-016 IDLE SHALL go to DRIVE when start=1; it SHALL latch mode, clear err_cnt, first_err_vec and pass, and set dut_in=0 and the hold counter to 0.
REQ-017 For start sampled at cycle t: busy SHALL be 1 from t+1, and pattern k SHALL be driven on cycles t+1+k*HOLD through t+(k+1)*HOLD.
REQ-018 dut_out SHALL be sampled on the last hold cycle of each pattern and compared with f(latched mode, dut_in).
REQ-019 On a mismatch, err_cnt SHALL increment, and first_err_vec SHALL load dut_in only when err_cnt was 0.
REQ-020 After pattern 2^N-1 is sampled, the FSM SHALL enter DONE; DONE lasts one cycle, at t+1+2^N*HOLD, with done=1, busy=0, pass=(err_cnt==0) and dut_in=0, then returns to IDLE.
REQ-021 start while in DRIVE or DONE SHALL be ignored; mode changes after latching SHALL be ignored.
REQ-022 err_cnt SHALL NOT saturate; width N+1 holds the maximum 2^N.
REQ-023 pattern and hold counters SHALL NOT wrap within a sweep; there is no wrap past 2^N-1.
REQ-024 err_cnt, pass and first_err_vec SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-025 rst=1 SHALL, on the next rising edge and in any state including mid-sweep, force IDLE with dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0 and all counters at 0.
REQ-026 rst SHALL take priority over start.

Configuration
REQ-027 Macro GATE_SWEEP_TRACE_EN SHALL control the truth-table trace.
- Defined: output tt_capture [2^N-1:0] is present. Bit k holds the dut_out sampled for pattern k. It is cleared on accepted start and on rst.
- Undefined: the port, register and logic are absent; all other behaviour is identical.

Structure
REQ-028 Package gate_sweep_pkg SHALL hold the mode localparams and the width function for err_cnt.
REQ-029 Sub-module gate_ref_model (combinational; inputs mode and vector; output expected bit) SHALL compute f.
REQ-030 Implementation size SHALL be roughly 120-400 lines of RTL.

Verification
All scenarios use N=4 and HOLD=10.
REQ-031 Correct NAND model, mode=1, start at cycle t -> done at t+161; err_cnt=0; pass=1.
REQ-032 DUT stuck at 1, mode=1 -> err_cnt=1; first_err_vec=4'hF; pass=0.
REQ-033 DUT is NAND, mode=0 (AND) -> err_cnt=16; first_err_vec=4'h0; pass=0.
REQ-034 rst asserted 50 cycles into the sweep -> next cycle busy=0, dut_in=0, err_cnt=0. A new start then completes as in REQ-031.
REQ-035 start pulsed and mode toggled to 3 during busy -> no restart; results equal REQ-031.
REQ-036 GATE_SWEEP_TRACE_EN defined, XOR DUT, mode=4 -> tt_capture=16'h6996; pass=1.
